writeback_rr_arbiter: RTL and testbench

WRITEBACK_RR_ARBITER -- requirements
Module: writeback_rr_arbiter

---
 rtl/writeback_rr_arbiter.sv | 93 +++++++++
 tb/tb_writeback_rr_arbiter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/writeback_rr_arbiter.sv
// Round-robin arbiter merging execution-unit writeback results into one registered result stage.
// One cycle from unit_done to wb_valid; the stage holds its result and withholds every ack while wb_valid & ~wb_ready.
module writeback_rr_arbiter #(
  parameter int NUM_UNITS  = 4,
  parameter int ID_WIDTH   = 3,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_UNITS-1:0]                  unit_done,
  input  logic [NUM_UNITS-1:0][ID_WIDTH-1:0]    unit_id,
  input  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]  unit_rd,
  output logic [NUM_UNITS-1:0]                  unit_ack,
  output logic                                  wb_valid,
  output logic [ID_WIDTH-1:0]                   wb_id,
  output logic [DATA_WIDTH-1:0]                 wb_data,
  output logic [$clog2(NUM_UNITS)-1:0]          wb_unit,
  input  logic                                  wb_ready
);

  localparam int UW = $clog2(NUM_UNITS);

  logic                  wb_valid_q, wb_valid_d;
  logic [ID_WIDTH-1:0]   wb_id_q, wb_id_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic [UW-1:0]         wb_unit_q, wb_unit_d;
  logic [UW-1:0]         ptr_q, ptr_d;

  logic          load_en;
  logic          any_req;
  logic          grant;
  logic [UW-1:0] sel;

  assign load_en = ~wb_valid_q | wb_ready;
  assign any_req = |unit_done;
  assign grant   = load_en & any_req & ~rst;

  // First requester at or above ptr, wrapping past the top unit back to 0.
  always_comb begin
    int  idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_UNITS) idx = idx - NUM_UNITS;
      if (!found && unit_done[idx]) begin
        found = 1'b1;
        sel   = UW'(idx);
      end
    end
  end

  always_comb begin
    unit_ack   = '0;
    wb_valid_d = wb_valid_q;
    wb_id_d    = wb_id_q;
    wb_data_d  = wb_data_q;
    wb_unit_d  = wb_unit_q;
    ptr_d      = ptr_q;
    if (load_en) wb_valid_d = any_req;
    if (grant) begin
      unit_ack[sel] = 1'b1;
      wb_id_d       = unit_id[sel];
      wb_data_d     = unit_rd[sel];
      wb_unit_d     = sel;
      ptr_d         = (int'(sel) == NUM_UNITS - 1) ? '0 : sel + UW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_id_q    <= '0;
      wb_data_q  <= '0;
      wb_unit_q  <= '0;
      ptr_q      <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_id_q    <= wb_id_d;
      wb_data_q  <= wb_data_d;
      wb_unit_q  <= wb_unit_d;
      ptr_q      <= ptr_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_id    = wb_id_q;
  assign wb_data  = wb_data_q;
  assign wb_unit  = wb_unit_q;

endmodule

// File: tb/tb_writeback_rr_arbiter.sv
// Directed bench for writeback_rr_arbiter with hand-computed expectations.
module tb_writeback_rr_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       unit_done;
  logic [3:0][2:0]  unit_id;
  logic [3:0][31:0] unit_rd;
  logic [3:0]       unit_ack;
  logic             wb_valid;
  logic [2:0]       wb_id;
  logic [31:0]      wb_data;
  logic [1:0]       wb_unit;
  logic             wb_ready;

  int n_tests = 0;
  int n_fail  = 0;

  writeback_rr_arbiter #(.NUM_UNITS(4), .ID_WIDTH(3), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .unit_done(unit_done), .unit_id(unit_id), .unit_rd(unit_rd),
    .unit_ack(unit_ack), .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data),
    .wb_unit(wb_unit), .wb_ready(wb_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wb_ready = 1'b1; unit_done = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      unit_id[i] = 3'(i);
      unit_rd[i] = 32'h0;
    end
    tick(); tick();
    check("rst_valid", 64'(wb_valid), 64'd0);
    check("rst_id",    64'(wb_id),    64'd0);
    check("rst_data",  64'(wb_data),  64'd0);
    check("rst_unit",  64'(wb_unit),  64'd0);
    check("rst_ack",   64'(unit_ack), 64'd0);

    // single request from unit 2
    rst = 1'b0; unit_done = 4'b0100; unit_id[2] = 3'd5; unit_rd[2] = 32'hDEADBEEF;
    #1 check("single_ack", 64'(unit_ack), 64'b0100);
    tick();
    unit_done = 4'b0000;
    check("single_valid", 64'(wb_valid), 64'd1);
    check("single_id",    64'(wb_id),    64'd5);
    check("single_data",  64'(wb_data),  64'hDEADBEEF);
    check("single_unit",  64'(wb_unit),  64'd2);

    // idle drain; ptr is now 3
    #1 check("drain_ack", 64'(unit_ack), 64'd0);
    tick();
    check("drain_valid", 64'(wb_valid), 64'd0);
    check("drain_data",  64'(wb_data),  64'hDEADBEEF);

    // wrap from ptr=3
    unit_done = 4'b0011;
    unit_id[0] = 3'd1; unit_rd[0] = 32'h100;
    unit_id[1] = 3'd2; unit_rd[1] = 32'h200;
    #1 check("wrap_ack", 64'(unit_ack), 64'b0001);
    tick();
    check("wrap_unit", 64'(wb_unit), 64'd0);
    // ptr must now be 1, so unit 1 wins even though unit 0 still requests
    #1 check("wrap_ptr_ack", 64'(unit_ack), 64'b0010);
    tick();
    check("wrap_ptr_unit", 64'(wb_unit), 64'd1);
    check("wrap_ptr_data", 64'(wb_data), 64'h200);

    // backpressure with unit 1 requesting again
    wb_ready = 1'b0; unit_done = 4'b0010; unit_id[1] = 3'd3; unit_rd[1] = 32'h201;
    for (int c = 0; c < 3; c++) begin
      #1 check("bp_ack", 64'(unit_ack), 64'd0);
      tick();
      check("bp_valid", 64'(wb_valid), 64'd1);
      check("bp_data",  64'(wb_data),  64'h200);
      check("bp_id",    64'(wb_id),    64'd2);
      check("bp_unit",  64'(wb_unit),  64'd1);
    end
    wb_ready = 1'b1;
    #1 check("bp_release_ack", 64'(unit_ack), 64'b0010);
    tick();
    check("bp_new_data", 64'(wb_data), 64'h201);
    check("bp_new_id",   64'(wb_id),   64'd3);

    // reset mid-stream with everyone requesting
    unit_done = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      unit_id[i] = 3'(i);
      unit_rd[i] = 32'hA0 + 32'(i);
    end
    rst = 1'b1;
    #1 check("midrst_ack", 64'(unit_ack), 64'd0);
    tick();
    check("midrst_valid", 64'(wb_valid), 64'd0);
    check("midrst_data",  64'(wb_data),  64'd0);
    #1 check("midrst_ack2", 64'(unit_ack), 64'd0);

    // rotation after release: 0,1,2,3,0
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1 check("rot_ack", 64'(unit_ack), 64'(4'b0001 << (k % 4)));
      tick();
      check("rot_valid", 64'(wb_valid), 64'd1);
      check("rot_unit",  64'(wb_unit),  64'(k % 4));
      check("rot_data",  64'(wb_data),  64'(32'hA0 + 32'(k % 4)));
    end

    // drop valid, then request with wb_ready low while empty; ptr is 1
    unit_done = 4'b0000;
    tick();
    check("empty_valid", 64'(wb_valid), 64'd0);
    wb_ready = 1'b0; unit_done = 4'b1000;
    #1 check("empty_nordy_ack", 64'(unit_ack), 64'b1000);
    tick();
    check("empty_nordy_unit", 64'(wb_unit), 64'd3);
    check("empty_nordy_data", 64'(wb_data), 64'hA3);

    // request withdrawn before ack, then another unit; ptr is 0
    unit_done = 4'b0001;
    #1 check("withdraw_ack0", 64'(unit_ack), 64'd0);
    tick();
    unit_done = 4'b0010; wb_ready = 1'b1;
    #1 check("withdraw_ack1", 64'(unit_ack), 64'b0010);
    tick();
    check("withdraw_unit", 64'(wb_unit), 64'd1);
    check("withdraw_data", 64'(wb_data), 64'hA1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
